ise_color_classifier: RTL

- Front-end stage of the image sorting engine; sits directly upstream of the sorter.
- Consumes the raw 24-bit RGB pixel stream, one image of PIX_PER_IMG pixels at a time, and classifies every pixel by dominant channel.
- At each image boundary it emits one result record to the sorter: dominant colour, image index, winning pixel count and an intensity sum.
- Owns the `busy` back-pressure seen by the pixel source.

---
 rtl/ise_color_classifier.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ise_color_classifier.sv
// Classifies each RGB pixel by dominant channel and emits one dominant-colour record per image.
// Latency: record visible 1 cycle after the last pixel; busy stalls only the last pixel while a record waits.
module ise_color_classifier #(
    parameter int PIX_PER_IMG = 16384,
    parameter int CNT_W       = 15,
    parameter int SUM_W       = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pixel_valid,
    input  logic [4:0]       image_in_index,
    input  logic [23:0]      pixel_in,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_color,
    output logic [4:0]       res_index,
    output logic [CNT_W-1:0] res_count,
    output logic [SUM_W-1:0] res_sum,
    output logic             idx_err
);

    localparam logic [0:0]       IDLE = 1'b0;
    localparam logic [0:0]       ACC  = 1'b1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIX_PER_IMG - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [4:0]       cur_idx_q, cur_idx_d;
    logic             idx_err_q, idx_err_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [SUM_W-1:0] sum_q [3];
    logic [SUM_W-1:0] sum_d [3];
    logic [CNT_W-1:0] cnt_inc [3];
    logic [SUM_W-1:0] sum_inc [3];

    logic             res_valid_q, res_valid_d;
    logic [1:0]       res_color_q, res_color_d;
    logic [4:0]       res_index_q, res_index_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic [SUM_W-1:0] res_sum_q, res_sum_d;

    logic [7:0] ch_r, ch_g, ch_b, ch_val;
    logic [1:0] cls, win;
    logic       accept, last_pix;

    assign ch_r = pixel_in[23:16];
    assign ch_g = pixel_in[15:8];
    assign ch_b = pixel_in[7:0];

    assign busy     = res_valid_q & ~res_ready & (state_q == ACC) & (pix_cnt_q == LAST);
    assign accept   = pixel_valid & ~busy;
    assign last_pix = accept & (state_q == ACC) & (pix_cnt_q == LAST);

    // Channel ties resolve R > G > B
    always_comb begin
        cls    = 2'd2;
        ch_val = ch_b;
        if (ch_r >= ch_g && ch_r >= ch_b) begin
            cls    = 2'd0;
            ch_val = ch_r;
        end else if (ch_g >= ch_b) begin
            cls    = 2'd1;
            ch_val = ch_g;
        end
    end

    // Running totals including the pixel on the inputs, so the last pixel folds into the record
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            cnt_inc[c] = cnt_q[c] + ((accept && cls == 2'(c)) ? CNT_W'(1) : CNT_W'(0));
            sum_inc[c] = sum_q[c] + ((accept && cls == 2'(c)) ? SUM_W'(ch_val) : SUM_W'(0));
        end
    end

    always_comb begin
        win = 2'd2;
        if (cnt_inc[0] >= cnt_inc[1] && cnt_inc[0] >= cnt_inc[2]) begin
            win = 2'd0;
        end else if (cnt_inc[1] >= cnt_inc[2]) begin
            win = 2'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        cur_idx_d = cur_idx_q;
        idx_err_d = idx_err_q;
        for (int c = 0; c < 3; c++) begin
            cnt_d[c] = cnt_inc[c];
            sum_d[c] = sum_inc[c];
        end
        if (accept) begin
            if (state_q == IDLE) begin
                state_d   = ACC;
                cur_idx_d = image_in_index;
                pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end else begin
                if (image_in_index != cur_idx_q) begin
                    idx_err_d = 1'b1;
                end
                if (last_pix) begin
                    state_d   = IDLE;
                    pix_cnt_d = '0;
                    for (int c = 0; c < 3; c++) begin
                        cnt_d[c] = '0;
                        sum_d[c] = '0;
                    end
                end else begin
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // A new record loading on the same edge as a handshake takes priority
    always_comb begin
        res_valid_d = res_valid_q;
        res_color_d = res_color_q;
        res_index_d = res_index_q;
        res_count_d = res_count_q;
        res_sum_d   = res_sum_q;
        if (last_pix) begin
            res_valid_d = 1'b1;
            res_color_d = win;
            res_index_d = cur_idx_q;
            res_count_d = cnt_inc[win];
            res_sum_d   = sum_inc[win];
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            res_color_d = '0;
            res_index_d = '0;
            res_count_d = '0;
            res_sum_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pix_cnt_q   <= '0;
            cur_idx_q   <= '0;
            idx_err_q   <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                cnt_q[c] <= '0;
                sum_q[c] <= '0;
            end
            res_valid_q <= 1'b0;
            res_color_q <= '0;
            res_index_q <= '0;
            res_count_q <= '0;
            res_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            cur_idx_q   <= cur_idx_d;
            idx_err_q   <= idx_err_d;
            for (int c = 0; c < 3; c++) begin
                cnt_q[c] <= cnt_d[c];
                sum_q[c] <= sum_d[c];
            end
            res_valid_q <= res_valid_d;
            res_color_q <= res_color_d;
            res_index_q <= res_index_d;
            res_count_q <= res_count_d;
            res_sum_q   <= res_sum_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_color = res_color_q;
    assign res_index = res_index_q;
    assign res_count = res_count_q;
    assign res_sum   = res_sum_q;
    assign idx_err   = idx_err_q;

endmodule
